// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serial "1011" pattern detector with a saturating match counter.
// Define SEQ_OVERLAP_EN to reuse the trailing "1" of a match as the start
// of the next pattern; leave it undefined to restart matching after each hit.
// All outputs are registered, so there is no combinational input-to-output path.
module seq_detect_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_vld,
    input  logic       clr,
    output logic       det,
    output logic [7:0] cnt,
    output logic [2:0] state
);

    // Named states with fixed encodings; the encoding is visible on the state port for debug.
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

    localparam logic [7:0] CntMax = 8'hFF;

    state_e     state_q;
    state_e     state_d;
    logic       det_q;
    logic       det_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       match;

    // A match completes when the final "1" is accepted while sitting in S101.
    assign match = din_vld && (state_q == S101) && din;

    // Next-state decode: advance only on accepted bits, and recover from illegal codes unconditionally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: begin
                if (din_vld) begin
                    state_d = din ? S1 : S0;
                end
            end
            S1: begin
                if (din_vld) begin
                    state_d = din ? S1 : S10;
                end
            end
            S10: begin
                if (din_vld) begin
                    state_d = din ? S101 : S0;
                end
            end
            S101: begin
                if (din_vld) begin
                    state_d = din ? S1011 : S10;
                end
            end
            S1011: begin
                if (din_vld) begin
`ifdef SEQ_OVERLAP_EN
                    state_d = din ? S1 : S10;
`else
                    state_d = din ? S1 : S0;
`endif
                end
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    // Pulse and counter next values: det follows the match, cnt counts matches and sticks at its maximum.
    always_comb begin
        det_d = match;
        cnt_d = cnt_q;
        if (match && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State, pulse and counter registers; reset wins over soft clear, and both discard the current sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            det_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else if (clr) begin
            state_q <= S0;
            det_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det   = det_q;
    assign cnt   = cnt_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed vector table plus hand-written multi-cycle
// sequences for the "1011" detector; expected values adapt to SEQ_OVERLAP_EN.
module tb_seq_detect_ctrl;

    typedef struct {
        string      name;
        logic       rst;
        logic       clr;
        logic       vld;
        logic       din;
        logic       expDet;
        logic [7:0] expCnt;
        logic [2:0] expState;
    } vec_t;

`ifdef SEQ_OVERLAP_EN
    localparam bit Overlap = 1'b1;
`else
    localparam bit Overlap = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       clr;
    logic       det;
    logic [7:0] cnt;
    logic [2:0] state;

    int vectorsApplied;
    int miscompares;

    vec_t vecs [0:15];

    seq_detect_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .clr     (clr),
        .det     (det),
        .cnt     (cnt),
        .state   (state)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs away from the rising edge, then wait for that edge to take effect.
    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic d);
        @(negedge clk);
        rst     = r;
        clr     = c;
        din_vld = v;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    // Compare all three registered outputs against expectations as one vector.
    task automatic checkOutput(input string name, input logic eDet, input logic [7:0] eCnt,
                               input logic [2:0] eState);
        vectorsApplied++;
        if (det !== eDet || cnt !== eCnt || state !== eState) begin
            miscompares++;
            $display("[TB] FAIL %s: got det=%0b cnt=%0d state=%0d, expected det=%0b cnt=%0d state=%0d",
                     name, det, cnt, state, eDet, eCnt, eState);
        end
    endtask

    // Convenience: one accepted bit followed by a check.
    task automatic bitCheck(input string name, input logic d, input logic eDet,
                            input logic [7:0] eCnt, input logic [2:0] eState);
        applyStimulus(1'b0, 1'b0, 1'b1, d);
        checkOutput(name, eDet, eCnt, eState);
    endtask

    initial begin
        logic [7:0] expCnt;
        vectorsApplied = 0;
        miscompares    = 0;
        rst     = 1'b1;
        clr     = 1'b0;
        din_vld = 1'b0;
        din     = 1'b0;

        // Table: reset, the 1011011 stream, combined rst+clr, and a hold cycle.
        vecs[0]  = '{"reset",         1, 0, 0, 0, 0, 8'd0, 3'd0};
        vecs[1]  = '{"stream b1",     0, 0, 1, 1, 0, 8'd0, 3'd1};
        vecs[2]  = '{"stream b2",     0, 0, 1, 0, 0, 8'd0, 3'd2};
        vecs[3]  = '{"stream b3",     0, 0, 1, 1, 0, 8'd0, 3'd3};
        vecs[4]  = '{"stream b4",     0, 0, 1, 1, 1, 8'd1, 3'd4};
        vecs[5]  = '{"stream b5",     0, 0, 1, 0, 0, 8'd1, Overlap ? 3'd2 : 3'd0};
        vecs[6]  = '{"stream b6",     0, 0, 1, 1, 0, 8'd1, Overlap ? 3'd3 : 3'd1};
        vecs[7]  = '{"stream b7",     0, 0, 1, 1, Overlap, Overlap ? 8'd2 : 8'd1,
                     Overlap ? 3'd4 : 3'd1};
        vecs[8]  = '{"idle hold",     0, 0, 0, 0, 0, Overlap ? 8'd2 : 8'd1,
                     Overlap ? 3'd4 : 3'd1};
        vecs[9]  = '{"rst+clr",       1, 1, 1, 1, 0, 8'd0, 3'd0};
        vecs[10] = '{"post b1",       0, 0, 1, 1, 0, 8'd0, 3'd1};
        vecs[11] = '{"post b2",       0, 0, 1, 1, 0, 8'd0, 3'd1};
        vecs[12] = '{"post b3",       0, 0, 1, 0, 0, 8'd0, 3'd2};
        vecs[13] = '{"post b4 10->0", 0, 0, 1, 0, 0, 8'd0, 3'd0};
        vecs[14] = '{"post b5",       0, 0, 1, 1, 0, 8'd0, 3'd1};
        vecs[15] = '{"rst only",      1, 0, 1, 0, 0, 8'd0, 3'd0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].din);
            checkOutput(vecs[i].name, vecs[i].expDet, vecs[i].expCnt, vecs[i].expState);
        end

        // Gapped bits 1,0,1,1 with three invalid cycles between each; din toggles in gaps.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("gap reset", 1'b0, 8'd0, 3'd0);
        begin
            logic [3:0] bits;
            logic [2:0] sts [0:3];
            bits   = 4'b1011;
            sts[0] = 3'd1;
            sts[1] = 3'd2;
            sts[2] = 3'd3;
            sts[3] = 3'd4;
            for (int b = 0; b < 4; b++) begin
                bitCheck("gap bit", bits[3-b], (b == 3), (b == 3) ? 8'd1 : 8'd0, sts[b]);
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, ~bits[3-b]);
                    checkOutput("gap hold", 1'b0, (b == 3) ? 8'd1 : 8'd0, sts[b]);
                end
            end
        end

        // Reset in the middle of a partial match abandons it.
        bitCheck("pre-rst b1", 1'b1, 1'b0, 8'd1, 3'd1);
        bitCheck("pre-rst b2", 1'b0, 1'b0, 8'd1, 3'd2);
        bitCheck("pre-rst b3", 1'b1, 1'b0, 8'd1, 3'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("mid rst", 1'b0, 8'd0, 3'd0);
        bitCheck("after rst b1", 1'b1, 1'b0, 8'd0, 3'd1);
        bitCheck("after rst b2", 1'b0, 1'b0, 8'd0, 3'd2);
        bitCheck("after rst b3", 1'b1, 1'b0, 8'd0, 3'd3);
        bitCheck("after rst b4", 1'b1, 1'b1, 8'd1, 3'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after rst pulse end", 1'b0, 8'd1, 3'd4);

        // Build cnt up to 5, reach S101, then clear together with a completing bit.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clr prep reset", 1'b0, 8'd0, 3'd0);
        for (int k = 1; k <= 5; k++) begin
            bitCheck("clr prep b1", 1'b1, 1'b0, 8'(k - 1), 3'd1);
            bitCheck("clr prep b2", 1'b0, 1'b0, 8'(k - 1), 3'd2);
            bitCheck("clr prep b3", 1'b1, 1'b0, 8'(k - 1), 3'd3);
            bitCheck("clr prep b4", 1'b1, 1'b1, 8'(k), 3'd4);
        end
        bitCheck("clr s1", 1'b1, 1'b0, 8'd5, 3'd1);
        bitCheck("clr s10", 1'b0, 1'b0, 8'd5, 3'd2);
        bitCheck("clr s101", 1'b1, 1'b0, 8'd5, 3'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("clr with match", 1'b0, 8'd0, 3'd0);

        // 300 back-to-back patterns: cnt saturates at 255, det keeps pulsing.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sat reset", 1'b0, 8'd0, 3'd0);
        expCnt = 8'd0;
        for (int k = 1; k <= 300; k++) begin
            bitCheck("sat b1", 1'b1, 1'b0, expCnt, 3'd1);
            bitCheck("sat b2", 1'b0, 1'b0, expCnt, 3'd2);
            bitCheck("sat b3", 1'b1, 1'b0, expCnt, 3'd3);
            if (k <= 255) begin
                expCnt = 8'(k);
            end
            bitCheck("sat b4", 1'b1, 1'b1, expCnt, 3'd4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat final", 1'b0, 8'hFF, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 The port clk SHALL be an input, 1 bit wide: the system clock, with all state updated on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-004 The port din SHALL be an input, 1 bit wide: the serial data bit.
REQ-005 The port din_vld SHALL be an input, 1 bit wide: din is consumed only on a clock edge where din_vld=1.
REQ-006 The port clr SHALL be an input, 1 bit wide: a synchronous soft clear of the FSM, det and cnt.
REQ-007 The port det SHALL be an output, 1 bit wide: a one-cycle pulse marking a completed "1011" match.
REQ-008 The port cnt SHALL be an output, 8 bits wide: the saturating count of matches.
REQ-009 The port state SHALL be an output, 3 bits wide: the current FSM state encoding, for debug.

Function
REQ-010 The FSM SHALL have the states S0=3'd0, S1=3'd1, S10=3'd2, S101=3'd3 and S1011=3'd4, and SHALL treat unused codes 5-7 as S0 on the next edge.
REQ-011 The FSM SHALL advance only on an edge where din_vld=1, and SHALL hold all state when din_vld=0.
REQ-012 The FSM transitions SHALL be: S0: 1->S1, 0->S0; S1: 1->S1, 0->S10; S10: 1->S101, 0->S0; S101: 1->S1011, 0->S10.
REQ-013 The transitions out of S1011 SHALL be as selected under Configuration (REQ-024/REQ-025).
REQ-014 The register det SHALL be set on an edge only where din_vld=1, state=S101 and din=1, and SHALL be 0 on every other edge.
REQ-015 As a result of REQ-014, det SHALL be high for exactly one cycle, in the cycle after the accepting bit, regardless of later din_vld gaps.
REQ-016 The counter cnt SHALL increment by 1 on the same edge that det is set, SHALL saturate at 8'hFF, and SHALL never wrap.
REQ-017 When clr=1 (and rst=0), the next edge SHALL give state=S0, det=0 and cnt=0, and the din sample on that edge SHALL be discarded.
REQ-018 When rst=1 and clr=1 on the same edge, rst SHALL take priority; the result is identical to REQ-017.
REQ-019 When din_vld=1 and a match completes on the same edge that cnt=8'hFF, det SHALL still pulse and cnt SHALL hold at 8'hFF.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-021 An edge with rst=1 SHALL give state=S0, det=0 and cnt=8'h00, and SHALL abandon any partial match.
REQ-022 After rst falls, the first din_vld=1 edge SHALL be evaluated from S0; no match can complete before 4 accepted bits.

Configuration
REQ-023 The macro SEQ_OVERLAP_EN SHALL select between overlapping and non-overlapping detection at compile time.
REQ-024 With SEQ_OVERLAP_EN defined, the transitions out of S1011 SHALL be 1->S1 and 0->S10, so the trailing "1" is reused.
REQ-025 With SEQ_OVERLAP_EN undefined, the transitions out of S1011 SHALL be 1->S1 and 0->S0, so matching restarts and no suffix is reused.
REQ-026 All other behaviour and the port list SHALL be identical in both builds.

Verification
REQ-027 Bench scenario, overlap build: after reset, din_vld=1 continuously with din=1,0,1,1,0,1,1 -> det pulses after the 4th and 7th bits, and cnt=2.
REQ-028 Bench scenario, non-overlap build: the same stream as REQ-027 -> det pulses only after the 4th bit, and cnt=1.
REQ-029 Bench scenario: the bits 1,0,1,1 presented with din_vld=0 gaps of 3 cycles between each -> exactly one det pulse, 1 cycle after the 4th valid bit, and state holds during the gaps.
REQ-030 Bench scenario: 300 back-to-back "1011" patterns -> cnt reads 8'hFF from the 255th match onward, and det still pulses for every match.
REQ-031 Bench scenario: rst=1 asserted after 1,0,1 is accepted, then the stream 1,0,1,1 -> no det on the bit following reset, one det after the new 4th bit, and cnt=1.
REQ-032 Bench scenario: clr=1 together with a completing din=1 in state S101, with cnt=5 -> det=0, cnt=0 and state=S0 on the next cycle.
